neuron_accumulator: RTL
=======================

NEURON_ACCUMULATOR -- requirements
Module: neuron_accumulator

Interface
REQ-001 SHALL have parameter Width, default 24: word width of products, bias and sum (signed two's complement).
REQ-002 SHALL have parameter Magnitud, default 4: integer magnitude bits of the fixed-point format.
REQ-003 SHALL have parameter Precision, default 19: fractional bits (1.0 = 2^Precision).
REQ-004 SHALL have parameter NumInputs, default 8: products per neuron, range 1..255.
REQ-005 SHALL have port Clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port Rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port Start, input, 1: begin a new neuron sum.
REQ-008 SHALL have port ProdValid, input, 1: Prod/ProdErr valid this cycle.
REQ-009 SHALL have port Prod, input, Width: signed product from the fixed-point multiplier stage.
REQ-010 SHALL have port ProdErr, input, 1: multiplier overflow/underflow flag for Prod.
REQ-011 SHALL have port Bias, input, Width: signed neuron bias.
REQ-012 SHALL have port ProdReady, output, 1: block accepts a product this cycle.
REQ-013 SHALL have port Busy, output, 1: a sum is in progress.
REQ-014 SHALL have port SumOut, output, Width: registered saturated neuron sum.
REQ-015 SHALL have port SumValid, output, 1: one-cycle pulse, SumOut updated.
REQ-016 SHALL have port SatErr, output, 1: sticky error flag for the current/last sum.

Function
REQ-017 SHALL implement states IDLE, ACCUM, BIAS; Busy = (state != IDLE); ProdReady = (state == ACCUM).
REQ-018 In IDLE, Start SHALL load Acc=0, Count=0, SatErr=0 and enter ACCUM at the same edge; ProdValid in IDLE is ignored.
REQ-019 In ACCUM, a product is accepted on an edge where ProdValid && ProdReady; then Acc <= sat(Acc+Prod), Count++, SatErr |= ProdErr | addition saturated.
REQ-020 On acceptance of product number NumInputs, the state SHALL go to BIAS; cycles with ProdValid=0 SHALL hold all state.
REQ-021 In BIAS (exactly one cycle), SumOut <= sat(Acc+Bias), SatErr |= saturation, SumValid <= 1, state <= IDLE.
REQ-022 SumValid SHALL be high for exactly one cycle, two edges after the edge accepting the last product.
REQ-023 sat(): full Width+1-bit signed sum, clamped to 2^(Width-1)-1 if above, -2^(Width-1) if below; clamp sets saturation.
REQ-024 Start while Busy SHALL be ignored; Start in the cycle SumValid is high SHALL start a new sum normally.
REQ-025 SumOut and SatErr SHALL hold their values until the next BIAS cycle / next Start respectively.
REQ-026 Bias SHALL be sampled only in the BIAS cycle.

Reset
REQ-027 Rst_n low SHALL immediately force state IDLE, Acc=0, Count=0, SumOut=0, SumValid=0, SatErr=0, ProdReady=0, Busy=0, including mid-ACCUM or BIAS.
REQ-028 After Rst_n release, no sum SHALL begin without a new Start.

Structure
REQ-029 A shared package SHALL hold Width/Magnitud/Precision/Signo defaults, the saturation max/min constants and the state encoding.
REQ-030 One combinational sub-module saturating_adder (a, b -> sum, sat) SHALL be used, muxing Prod or Bias as operand b.
REQ-031 Count width SHALL be 8 bits.

Verification (Q4.19, NumInputs=4)
REQ-032 Assert Rst_n low two cycles after Start mid-ACCUM -> ProdReady, Busy, SumOut, SumValid, SatErr all 0 without waiting for a clock edge.
REQ-033 Products 0x080000, 0x080000, 0xFC0000, 0x020000, Bias 0x040000 -> SumOut 0x120000 (2.25), SumValid one cycle, two edges after last product, SatErr 0.
REQ-034 Four products 0x7FFFFF, Bias 0 -> SumOut 0x7FFFFF, SatErr 1.
REQ-035 Four products 0x800000, Bias 0x000001 -> SumOut 0x800001, SatErr 1.
REQ-036 Products 0x080000 x4 with ProdValid gaps of 0..3 cycles, Start pulsed during ACCUM, ProdErr=1 on the second product, Bias 0 -> SumOut 0x200000, SatErr 1, exactly 4 products accepted.
REQ-037 Start in the SumValid cycle -> Busy next cycle, previous SumOut held until the next SumValid.

Source files
------------

// File: rtl/neuron_accumulator_pkg.sv
// Shared fixed-point format defaults, saturation limits and FSM encoding for
// the neuron accumulator.
package neuron_accumulator_pkg;

  localparam int unsigned DefWidth     = 24;
  localparam int unsigned DefMagnitud  = 4;
  localparam int unsigned DefPrecision = 19;
  localparam int unsigned Signo        = 1;
  localparam int unsigned CountWidth   = 8;

  localparam logic [DefWidth-1:0] SatMax = {1'b0, {(DefWidth-1){1'b1}}};
  localparam logic [DefWidth-1:0] SatMin = {1'b1, {(DefWidth-1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StBias
  } state_e;

endpackage

// File: rtl/saturating_adder.sv
// Combinational signed adder that clamps to the representable range and flags
// whenever clamping occurred.
module saturating_adder
  import neuron_accumulator_pkg::*;
#(
  parameter int unsigned Width = DefWidth
) (
  input  logic signed [Width-1:0] a_i,
  input  logic signed [Width-1:0] b_i,
  output logic signed [Width-1:0] sum_o,
  output logic                    sat_o
);

  localparam logic [Width-1:0] Max = {1'b0, {(Width-1){1'b1}}};
  localparam logic [Width-1:0] Min = {1'b1, {(Width-1){1'b0}}};

  logic [Width:0] full;

  assign full = {a_i[Width-1], a_i} + {b_i[Width-1], b_i};

  // Overflow when the extended sign bit disagrees with the result sign bit;
  // the extended bit tells which rail was crossed.
  always_comb begin
    sat_o = full[Width] ^ full[Width-1];
    sum_o = full[Width-1:0];
    if (sat_o) begin
      sum_o = full[Width] ? Min : Max;
    end
  end

endmodule

// File: rtl/neuron_accumulator.sv
// Accumulates NumInputs signed products plus a bias into a saturated neuron sum,
// with a sticky error flag covering multiplier errors and any clamping.
module neuron_accumulator
  import neuron_accumulator_pkg::*;
#(
  parameter int unsigned Width     = DefWidth,
  parameter int unsigned Magnitud  = DefMagnitud,
  parameter int unsigned Precision = DefPrecision,
  parameter int unsigned NumInputs = 8
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    Start,
  input  logic                    ProdValid,
  input  logic signed [Width-1:0] Prod,
  input  logic                    ProdErr,
  input  logic signed [Width-1:0] Bias,
  output logic                    ProdReady,
  output logic                    Busy,
  output logic signed [Width-1:0] SumOut,
  output logic                    SumValid,
  output logic                    SatErr
);

  if (Signo + Magnitud + Precision != Width) begin : g_bad_format
    $error("sign + magnitude + precision bits must equal Width");
  end
  if (NumInputs < 1 || NumInputs > 255) begin : g_bad_num_inputs
    $error("NumInputs must be in 1..255");
  end

  localparam logic [CountWidth-1:0] LastIdx = CountWidth'(NumInputs - 1);

  state_e                  state_q, state_d;
  logic signed [Width-1:0] acc_q, acc_d;
  logic signed [Width-1:0] sum_q, sum_d;
  logic [CountWidth-1:0]   count_q, count_d;
  logic                    sat_err_q, sat_err_d;
  logic                    sum_valid_q, sum_valid_d;

  logic signed [Width-1:0] add_b;
  logic signed [Width-1:0] add_sum;
  logic                    add_sat;

  // The single adder serves both phases; Bias is only looked at in StBias.
  assign add_b = (state_q == StBias) ? Bias : Prod;

  saturating_adder #(
    .Width(Width)
  ) u_sat_add (
    .a_i  (acc_q),
    .b_i  (add_b),
    .sum_o(add_sum),
    .sat_o(add_sat)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    count_d     = count_q;
    sat_err_d   = sat_err_q;
    sum_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          acc_d     = '0;
          count_d   = '0;
          sat_err_d = 1'b0;
          state_d   = StAccum;
        end
      end
      StAccum: begin
        if (ProdValid) begin
          acc_d     = add_sum;
          count_d   = count_q + 1'b1;
          sat_err_d = sat_err_q | ProdErr | add_sat;
          if (count_q == LastIdx) begin
            state_d = StBias;
          end
        end
      end
      StBias: begin
        sum_d       = add_sum;
        sat_err_d   = sat_err_q | add_sat;
        sum_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      sum_q       <= '0;
      count_q     <= '0;
      sat_err_q   <= 1'b0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      sat_err_q   <= sat_err_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign ProdReady = (state_q == StAccum);
  assign Busy      = (state_q != StIdle);
  assign SumOut    = sum_q;
  assign SumValid  = sum_valid_q;
  assign SatErr    = sat_err_q;

endmodule
